// File: rtl/ddr_avalon_responder_if.sv
// Avalon-MM write and read ports of the DDR window responder.
// master = recorder/test side, slave = responder side.
interface ddr_avalon_responder_if;
   logic [23:0] ddr_write_address;
   logic        ddr_write_write;
   logic [31:0] ddr_write_writedata;
   logic [3:0]  ddr_write_byteenable;
   logic        ddr_write_waitrequest;
   logic [23:0] ddr_read_address;
   logic        ddr_read_read;
   logic        ddr_read_waitrequest;
   logic        ddr_read_readdatavalid;
   logic [31:0] ddr_read_readdata;

   modport master (
      output ddr_write_address, ddr_write_write, ddr_write_writedata, ddr_write_byteenable,
      output ddr_read_address, ddr_read_read,
      input  ddr_write_waitrequest, ddr_read_waitrequest,
      input  ddr_read_readdatavalid, ddr_read_readdata
   );

   modport slave (
      input  ddr_write_address, ddr_write_write, ddr_write_writedata, ddr_write_byteenable,
      input  ddr_read_address, ddr_read_read,
      output ddr_write_waitrequest, ddr_read_waitrequest,
      output ddr_read_readdatavalid, ddr_read_readdata
   );
endinterface

// File: rtl/ddr_avalon_responder.sv
// Avalon-MM responder backed by on-chip RAM, standing in for the DDR3 window.
// Latency: write commits at accept; read data returns READ_LATENCY cycles after accept, in order.
// Backpressure: read waitrequest at MAX_OUTSTANDING in flight; LFSR stalls when DDR_RESP_STALL_EN is defined.
module ddr_avalon_responder #(
   parameter int ADDR_W          = 12,
   parameter int READ_LATENCY    = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   ddr_avalon_responder_if.slave  bus,
   output logic [15:0]            wr_count,
   output logic [15:0]            rd_count
);
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PS = READ_LATENCY - 1;

   logic [31:0]       mem [2**ADDR_W];
   logic              wr_acc;
   logic              rd_acc;
   logic [ADDR_W-1:0] wa;
   logic [ADDR_W-1:0] ra;
   logic [31:0]       rd_word;
   logic [PS-1:0]     pipe_vld;
   logic [31:0]       pipe_dat [PS];
   logic [OW-1:0]     outstanding;
   logic              read_stall;
   logic              write_stall;
   logic              unused_addr_bits;

   assign wa = bus.ddr_write_address[ADDR_W-1:0];
   assign ra = bus.ddr_read_address[ADDR_W-1:0];
   assign unused_addr_bits = ^{bus.ddr_write_address[23:ADDR_W], bus.ddr_read_address[23:ADDR_W]};

   assign bus.ddr_write_waitrequest = reset | write_stall;
   assign bus.ddr_read_waitrequest  = reset | (outstanding == OW'(MAX_OUTSTANDING)) | read_stall;

   assign wr_acc = bus.ddr_write_write & ~bus.ddr_write_waitrequest;
   assign rd_acc = bus.ddr_read_read & ~bus.ddr_read_waitrequest;

`ifdef DDR_RESP_STALL_EN
   logic [15:0] lfsr;
   logic        lfsr_fb;

   // Right-shifting Fibonacci form of taps 16,14,13,11.
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   always_ff @(posedge clock) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr_fb, lfsr[15:1]};
   end

   assign write_stall = lfsr[0] & lfsr[1];
   assign read_stall  = lfsr[2] & lfsr[3];
`else
   assign write_stall = 1'b0;
   assign read_stall  = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (wr_acc) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.ddr_write_byteenable[b]) mem[wa][8*b +: 8] <= bus.ddr_write_writedata[8*b +: 8];
         end
      end
   end

   // Same-edge write to the read address is forwarded so the read sees the new bytes.
   always_comb begin
      rd_word = mem[ra];
      if (wr_acc && (wa == ra)) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.ddr_write_byteenable[b]) rd_word[8*b +: 8] = bus.ddr_write_writedata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      pipe_dat[0] <= rd_word;
      for (int k = 1; k < PS; k++) pipe_dat[k] <= pipe_dat[k-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pipe_vld                   <= '0;
         bus.ddr_read_readdatavalid <= 1'b0;
         bus.ddr_read_readdata      <= 32'h0;
         outstanding                <= '0;
         wr_count                   <= 16'h0;
         rd_count                   <= 16'h0;
      end else begin
         pipe_vld[0] <= rd_acc;
         for (int k = 1; k < PS; k++) pipe_vld[k] <= pipe_vld[k-1];
         bus.ddr_read_readdatavalid <= pipe_vld[PS-1];
         if (pipe_vld[PS-1]) bus.ddr_read_readdata <= pipe_dat[PS-1];
         case ({rd_acc, bus.ddr_read_readdatavalid})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: outstanding <= outstanding;
         endcase
         if (wr_acc)                     wr_count <= wr_count + 16'd1;
         if (bus.ddr_read_readdatavalid) rd_count <= rd_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_ddr_avalon_responder.sv
// Directed bench for ddr_avalon_responder (READ_LATENCY 4, MAX_OUTSTANDING 2).
module tb_ddr_avalon_responder;
   localparam int LIMIT = 200;
`ifdef DDR_RESP_STALL_EN
   localparam int NW = 1000;
`else
   localparam int NW = 200;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] wr_count;
   logic [15:0] rd_count;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          exp_wr = 0;
   int          exp_rd = 0;
   int          max_out = 0;
   logic        seen_wwait = 1'b0;
   logic        seen_rwait = 1'b0;
   logic [31:0] rq [$];
   int          rcyc [$];
   logic [31:0] model [NW];

   ddr_avalon_responder_if bus ();

   ddr_avalon_responder #(.ADDR_W(12), .READ_LATENCY(4), .MAX_OUTSTANDING(2)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .wr_count (wr_count),
      .rd_count (rd_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (bus.ddr_read_readdatavalid === 1'b1) begin
         rq.push_back(bus.ddr_read_readdata);
         rcyc.push_back(cyc);
      end
      if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
      if (!reset && bus.ddr_write_waitrequest) seen_wwait = 1'b1;
      if (!reset && bus.ddr_read_waitrequest)  seen_rwait = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] be);
      int n = 0;
      @(negedge clock);
      bus.ddr_write_address    = a;
      bus.ddr_write_writedata  = d;
      bus.ddr_write_byteenable = be;
      bus.ddr_write_write      = 1'b1;
      while (bus.ddr_write_waitrequest !== 1'b0 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check("wr_wait_bound", 32'(n < LIMIT), 32'd1);
      @(posedge clock);
      #1;
      bus.ddr_write_write = 1'b0;
      exp_wr++;
   endtask

   task automatic rd(input logic [23:0] a, output logic [31:0] d, output int lat);
      int n = 0;
      int acc;
      rq.delete();
      rcyc.delete();
      @(negedge clock);
      bus.ddr_read_address = a;
      bus.ddr_read_read    = 1'b1;
      while (bus.ddr_read_waitrequest !== 1'b0 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check("rd_wait_bound", 32'(n < LIMIT), 32'd1);
      @(posedge clock);
      #1;
      bus.ddr_read_read = 1'b0;
      acc = cyc;
      n = 0;
      while (rq.size() == 0 && n < LIMIT) begin
         @(posedge clock);
         n++;
      end
      check("rd_return_bound", 32'(n < LIMIT), 32'd1);
      if (rq.size() > 0) begin
         d   = rq.pop_front();
         lat = rcyc.pop_front() - acc;
         exp_rd++;
      end else begin
         d   = 'x;
         lat = -1;
      end
   endtask

   // Holds read high and steps the address on each accept; returns waitrequest seen after the 2nd accept.
   task automatic burst(input int cnt, output logic w2);
      int acc = 0;
      int n = 0;
      w2 = 1'b0;
      @(negedge clock);
      bus.ddr_read_address = 24'd0;
      bus.ddr_read_read    = 1'b1;
      while (acc < cnt && n < LIMIT) begin
         if (bus.ddr_read_waitrequest === 1'b0) begin
            @(posedge clock);
            acc++;
            #1;
            if (acc < cnt) bus.ddr_read_address = 24'(acc);
            else           bus.ddr_read_read = 1'b0;
            @(negedge clock);
            if (acc == 2) w2 = bus.ddr_read_waitrequest;
         end else begin
            @(negedge clock);
         end
         n++;
      end
      bus.ddr_read_read = 1'b0;
      check("burst_accept_bound", 32'(acc), 32'(cnt));
   endtask

   initial begin
      logic [31:0] d;
      int          lat;
      int          n;
      logic        w2;

      bus.ddr_write_address    = '0;
      bus.ddr_write_write      = 1'b0;
      bus.ddr_write_writedata  = '0;
      bus.ddr_write_byteenable = '0;
      bus.ddr_read_address     = '0;
      bus.ddr_read_read        = 1'b0;

      // reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_wwait", 32'(bus.ddr_write_waitrequest), 32'd1);
      check("rst_rwait", 32'(bus.ddr_read_waitrequest), 32'd1);
      check("rst_rdv", 32'(bus.ddr_read_readdatavalid), 32'd0);
      check("rst_rdata", bus.ddr_read_readdata, 32'h0);
      check("rst_wr_count", 32'(wr_count), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      reset = 1'b0;
      @(negedge clock);
`ifndef DDR_RESP_STALL_EN
      check("post_rst_wwait", 32'(bus.ddr_write_waitrequest), 32'd0);
      check("post_rst_rwait", 32'(bus.ddr_read_waitrequest), 32'd0);
`endif

      // basic write / read with latency
      wr(24'd5, 32'hDEADBEEF, 4'hF);
      rd(24'd5, d, lat);
      check("rd5_data", d, 32'hDEADBEEF);
      check("rd5_latency", 32'(lat), 32'd3);
      @(negedge clock);
      check("wr_count_1", 32'(wr_count), 32'd1);
      check("rd_count_1", 32'(rd_count), 32'd1);
      repeat (2) @(negedge clock);
      check("rdv_low_idle", 32'(bus.ddr_read_readdatavalid), 32'd0);
      check("rdata_hold", bus.ddr_read_readdata, 32'hDEADBEEF);

      // byte enables
      wr(24'd7, 32'h11223344, 4'hF);
      wr(24'd7, 32'hAABBCCDD, 4'b0101);
      rd(24'd7, d, lat);
      check("be_merge", d, 32'h11BB33DD);
      wr(24'd7, 32'hFFFFFFFF, 4'h0);
      rd(24'd7, d, lat);
      check("be_zero_nochange", d, 32'h11BB33DD);
      @(negedge clock);
      check("be_zero_counted", 32'(wr_count), 32'd4);

      // back-to-back reads limited by outstanding count
      for (int i = 0; i < 8; i++) wr(24'(i), 32'hA0000000 + 32'(i), 4'hF);
      rq.delete();
      rcyc.delete();
      max_out = 0;
      burst(8, w2);
      check("wait_after_2nd", 32'(w2), 32'd1);
      n = 0;
      while (rq.size() < 8 && n < LIMIT) begin
         @(posedge clock);
         n++;
      end
      check("burst_returns", 32'(rq.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         d = (rq.size() > 0) ? rq.pop_front() : 32'hxxxxxxxx;
         check($sformatf("burst_data_%0d", i), d, 32'hA0000000 + 32'(i));
      end
      check("max_outstanding", 32'(max_out), 32'd2);
      exp_rd += 8;

      // simultaneous write and read, then address aliasing
      rq.delete();
      rcyc.delete();
      @(negedge clock);
      bus.ddr_write_address    = 24'd3;
      bus.ddr_write_writedata  = 32'h0000CAFE;
      bus.ddr_write_byteenable = 4'hF;
      bus.ddr_write_write      = 1'b1;
      bus.ddr_read_address     = 24'd3;
      bus.ddr_read_read        = 1'b1;
      n = 0;
      while ((bus.ddr_write_waitrequest !== 1'b0 || bus.ddr_read_waitrequest !== 1'b0) && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      check("same_edge_bound", 32'(n < LIMIT), 32'd1);
      @(posedge clock);
      #1;
      bus.ddr_write_write = 1'b0;
      bus.ddr_read_read   = 1'b0;
      exp_wr++;
      n = 0;
      while (rq.size() == 0 && n < LIMIT) begin
         @(posedge clock);
         n++;
      end
      d = (rq.size() > 0) ? rq.pop_front() : 32'hxxxxxxxx;
      check("write_first", d, 32'h0000CAFE);
      exp_rd++;
      wr(24'd4096 + 24'd3, 32'h12345678, 4'hF);
      rd(24'd3, d, lat);
      check("alias", d, 32'h12345678);
      @(negedge clock);
      check("wr_count_mid", 32'(wr_count), 32'(exp_wr));
      check("rd_count_mid", 32'(rd_count), 32'(exp_rd));

      // reset with reads in flight
      burst(3, w2);
      @(negedge clock);
      reset = 1'b1;
      rq.delete();
      rcyc.delete();
      repeat (2) @(negedge clock);
      check("midrst_wwait", 32'(bus.ddr_write_waitrequest), 32'd1);
      check("midrst_rwait", 32'(bus.ddr_read_waitrequest), 32'd1);
      check("midrst_wr_count", 32'(wr_count), 32'd0);
      check("midrst_rd_count", 32'(rd_count), 32'd0);
      reset = 1'b0;
      exp_wr = 0;
      exp_rd = 0;
      repeat (12) @(negedge clock);
      check("no_rdv_after_rst", 32'(rq.size()), 32'd0);
      rd(24'd3, d, lat);
      check("ram_kept", d, 32'h12345678);

      // random traffic from a clean reset
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      exp_wr = 0;
      exp_rd = 0;
      seen_wwait = 1'b0;
      seen_rwait = 1'b0;
      for (int i = 0; i < NW; i++) begin
         model[i] = $urandom;
         wr(24'(i), model[i], 4'hF);
      end
      for (int i = 0; i < NW; i++) begin
         rd(24'(i), d, lat);
         check($sformatf("rand_data_%0d", i), d, model[i]);
      end
      @(negedge clock);
      check("rand_wr_count", 32'(wr_count), 32'(NW));
      check("rand_rd_count", 32'(rd_count), 32'(NW));
`ifdef DDR_RESP_STALL_EN
      check("seen_wwait", 32'(seen_wwait), 32'd1);
      check("seen_rwait", 32'(seen_rwait), 32'd1);
`else
      check("no_wwait", 32'(seen_wwait), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
